router_pkt_src: RTL and testbench
=================================

# router_pkt_src

Synthesizable packet source that sits directly upstream of `router_top` and drives its `pkt_valid`/`data_in` inputs under `busy` flow control. On a single-cycle request it emits one complete router packet: a header byte, 1–63 pseudo-random payload bytes from an 8-bit LFSR, and a trailing even-parity byte. It is used for on-chip traffic generation and for the system-level bench in place of task-driven stimulus.

## Interface
Parameters:
- `GAP_CYCLES`, 2, idle cycles inserted after each packet's parity byte before `ready` reasserts (0–15).

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request pulse; sampled only while `ready`=1.
- `dest_addr` in 2: destination port (0–2); sampled with `start`.
- `payload_len` in 6: payload byte count (1–63); sampled with `start`.
- `seed` in 8: LFSR seed; sampled with `start`.
- `corrupt` in 1: error injection; sampled with `start`; when 1, the parity byte bit 0 is inverted.
- `busy` in 1: router busy; a byte transfers only on an edge where `busy`=0.
- `pkt_valid` out 1: to router `pkt_valid`.
- `pkt_data` out 8: to router `data_in`.
- `ready` out 1: idle and able to accept `start`.
- `done` out 1: one-cycle pulse after the parity byte transfers.
- `reject` out 1: one-cycle pulse when `start` carries an illegal request.
- `pkt_count` out 16: number of packets completed; wraps from 0xFFFF to 0.

## Operation
- All outputs are registered.
- States:
  - IDLE: `ready`=1.
  - HEADER: `pkt_valid`=1, `pkt_data`={len,addr}.
  - PAYLOAD: `pkt_valid`=1, `pkt_data`=LFSR value.
  - PARITY: `pkt_valid`=0, `pkt_data`=parity byte.
  - GAP: `pkt_valid`=0, `pkt_data` holds the parity value.
- IDLE with `start`=1:
  - If `dest_addr`=3 or `payload_len`=0: pulse `reject`, stay in IDLE, latch nothing.
  - Otherwise: latch all request inputs and go to HEADER.
- Transfer: at each edge with `busy`=0 in HEADER, PAYLOAD or PARITY, the current byte counts as accepted and the block advances. With `busy`=1 the state, `pkt_data` and `pkt_valid` hold.
- HEADER → PAYLOAD when the header is accepted.
- PAYLOAD:
  - Counts accepted bytes.
  - Goes to PARITY when the accepted count equals `payload_len`.
- PARITY → GAP when the parity byte is accepted; `done` pulses and `pkt_count` increments.
- GAP:
  - Counts `GAP_CYCLES` cycles (ignores `busy`), then returns to IDLE.
  - With `GAP_CYCLES`=0, GAP is skipped and the block goes straight to IDLE.
- LFSR:
  - 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1 (shift right; XOR 0xB8 when the shifted-out bit is 1).
  - Loaded with `seed`; a seed of 0x00 is replaced by 0x01.
  - Payload byte 0 is the seed value. The LFSR advances only on an accepted payload byte.
- Parity: XOR of the header and all payload bytes, accumulated on acceptance. If `corrupt` was latched, bit 0 is inverted.
- `start` outside IDLE is ignored; it is neither queued nor rejected.

## Timing
- Reset values: `pkt_valid`=0, `pkt_data`=0x00, `ready`=1, `done`=0, `reject`=0, `pkt_count`=0, state IDLE, LFSR 0x01.
- Reset asserted mid-packet: at that edge all registers take their reset values. `pkt_valid` drops in the next cycle. The partial packet is abandoned and `pkt_count` is cleared.
- Cycle numbering for a legal `start` accepted at edge E0:
  - The header is driven in the cycle after E0.
  - With `busy`=0 throughout, the header transfers at E1 and payload k at E(k+2).
  - The parity byte transfers at E(N+2), where N is the payload length.
  - `done` is high in the cycle after E(N+2).
  - `ready` returns GAP_CYCLES+1 cycles after E(N+2).
- Each `busy`=1 edge during HEADER, PAYLOAD or PARITY adds exactly one cycle.
- `reject` is high in the cycle after the offending edge. `ready` stays 1.

## Test plan
- Basic packet: `dest_addr`=0, len 14, seed 0xA5, `busy`=0. Required: header 0x38; payload byte 0 is 0xA5 followed by the LFSR sequence; `pkt_valid` high for 15 cycles; parity equals XOR of the 15 bytes; `done` after E16; `pkt_count`=1.
- Minimum packet: addr 2, len 1, seed 0x5A. Required: bytes 0x06, 0x5A, parity 0x5C; repeating with `corrupt`=1 gives parity 0x5D.
- Busy stall: `busy`=1 for 3 cycles during payload byte 5. Required: byte 5 holds on `pkt_data` for 4 cycles, no byte is skipped or duplicated, and `done` arrives 3 cycles later than the no-stall case.
- Illegal requests: `dest_addr`=3, or len 0. Required: `reject` pulses for one cycle, `pkt_valid` stays 0, `pkt_count` is unchanged.
- `start` held high through the packet and the GAP. Required: exactly one packet is emitted, and the next packet begins only when `ready`=1 after 2 GAP cycles.
- Reset mid-payload (byte 7 of 14): `pkt_valid`=0 in the next cycle; `ready`=1 and `pkt_count`=0; a new `start` then produces a clean packet.

Source files
------------

// File: rtl/router_pkt_src_if.sv
// Request and router-side signals of the packet source.
// master = the packet source, slave = the requester plus router.
interface router_pkt_src_if;
  logic        start;
  logic [1:0]  dest_addr;
  logic [5:0]  payload_len;
  logic [7:0]  seed;
  logic        corrupt;
  logic        busy;
  logic        pkt_valid;
  logic [7:0]  pkt_data;
  logic        ready;
  logic        done;
  logic        reject;
  logic [15:0] pkt_count;

  modport master (
    input  start, dest_addr, payload_len, seed, corrupt, busy,
    output pkt_valid, pkt_data, ready, done, reject, pkt_count
  );

  modport slave (
    output start, dest_addr, payload_len, seed, corrupt, busy,
    input  pkt_valid, pkt_data, ready, done, reject, pkt_count
  );
endinterface

// File: rtl/router_pkt_src.sv
// Router packet generator: header, LFSR payload, then parity byte, under busy flow control.
// Every output comes straight from a flop.
module router_pkt_src #(
  parameter int GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  router_pkt_src_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    lfsr_step = {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  state_t      state_q, state_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic [7:0]  pkt_data_q, pkt_data_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        reject_q, reject_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [5:0]  len_q, len_d;
  logic        corrupt_q, corrupt_d;
  logic [7:0]  par_q, par_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;

  always_comb begin
    state_d     = state_q;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    reject_d    = 1'b0;
    pkt_count_d = pkt_count_q;
    lfsr_d      = lfsr_q;
    len_d       = len_q;
    corrupt_d   = corrupt_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.dest_addr == 2'd3 || bus.payload_len == 6'd0) begin
            reject_d = 1'b1;
          end else begin
            state_d     = S_HEADER;
            ready_d     = 1'b0;
            pkt_valid_d = 1'b1;
            pkt_data_d  = {bus.payload_len, bus.dest_addr};
            len_d       = bus.payload_len;
            corrupt_d   = bus.corrupt;
            lfsr_d      = (bus.seed == 8'h00) ? 8'h01 : bus.seed;
            par_d       = 8'h00;
            cnt_d       = 6'd0;
          end
        end
      end
      S_HEADER: begin
        if (!bus.busy) begin
          state_d    = S_PAYLOAD;
          par_d      = par_q ^ pkt_data_q;
          pkt_data_d = lfsr_q;
        end
      end
      S_PAYLOAD: begin
        if (!bus.busy) begin
          par_d = par_q ^ pkt_data_q;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q + 6'd1 == len_q) begin
            // Parity goes out with pkt_valid low, so the router sees it as the trailing byte.
            state_d     = S_PARITY;
            pkt_valid_d = 1'b0;
            pkt_data_d  = par_q ^ pkt_data_q ^ {7'd0, corrupt_q};
          end else begin
            lfsr_d     = lfsr_step(lfsr_q);
            pkt_data_d = lfsr_step(lfsr_q);
          end
        end
      end
      S_PARITY: begin
        if (!bus.busy) begin
          done_d      = 1'b1;
          pkt_count_d = pkt_count_q + 16'd1;
          gap_d       = 4'd0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= 8'h00;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      reject_q    <= 1'b0;
      pkt_count_q <= 16'd0;
      lfsr_q      <= 8'h01;
      len_q       <= 6'd0;
      corrupt_q   <= 1'b0;
      par_q       <= 8'h00;
      cnt_q       <= 6'd0;
      gap_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      reject_q    <= reject_d;
      pkt_count_q <= pkt_count_d;
      lfsr_q      <= lfsr_d;
      len_q       <= len_d;
      corrupt_q   <= corrupt_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_data  = pkt_data_q;
  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.reject    = reject_q;
  assign bus.pkt_count = pkt_count_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// Directed bench for router_pkt_src with GAP_CYCLES=2; expected bytes are precomputed by hand.
module tb_router_pkt_src;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  router_pkt_src_if bus ();

  router_pkt_src #(.GAP_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // seed 0xA5 payload sequence, 14 bytes; header 0x38, parity 0x25
  logic [7:0] pay [14] = '{8'hA5, 8'hEA, 8'h75, 8'h82, 8'h41, 8'h98, 8'h4C,
                           8'h26, 8'h13, 8'hB1, 8'hE0, 8'h70, 8'h38, 8'h1C};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] a, input logic [5:0] l, input logic [7:0] s, input logic c);
    bus.start = 1'b1; bus.dest_addr = a; bus.payload_len = l; bus.seed = s; bus.corrupt = c;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic gap_to_ready();
    tick(); chk("gap1_ready", 16'(bus.ready), 16'd0);
    tick(); chk("gap_end_ready", 16'(bus.ready), 16'd1);
  endtask

  task automatic min_pkt(input logic c, input logic [7:0] par, input logic [15:0] cnt);
    req(2'd2, 6'd1, 8'h5A, c);
    chk("min_hdr", 16'(bus.pkt_data), 16'h06);
    tick(); chk("min_pay", 16'(bus.pkt_data), 16'h5A);
    chk("min_pay_vld", 16'(bus.pkt_valid), 16'd1);
    tick(); chk("min_par", 16'(bus.pkt_data), 16'(par));
    chk("min_par_vld", 16'(bus.pkt_valid), 16'd0);
    tick(); chk("min_done", 16'(bus.done), 16'd1);
    chk("min_count", bus.pkt_count, cnt);
    gap_to_ready();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; bus.start = 1'b0; bus.dest_addr = 2'd0; bus.payload_len = 6'd0;
    bus.seed = 8'h00; bus.corrupt = 1'b0; bus.busy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 16'(bus.pkt_valid), 16'd0);
    chk("rst_data", 16'(bus.pkt_data), 16'h00);
    chk("rst_ready", 16'(bus.ready), 16'd1);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_reject", 16'(bus.reject), 16'd0);
    chk("rst_count", bus.pkt_count, 16'd0);

    // basic packet
    req(2'd0, 6'd14, 8'hA5, 1'b0);
    chk("basic_hdr", 16'(bus.pkt_data), 16'h38);
    chk("basic_hdr_vld", 16'(bus.pkt_valid), 16'd1);
    chk("basic_busy_ready", 16'(bus.ready), 16'd0);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("basic_pay_vld", 16'(bus.pkt_valid), 16'd1);
      chk($sformatf("basic_pay%0d", k), 16'(bus.pkt_data), 16'(pay[k]));
    end
    tick();
    chk("basic_par", 16'(bus.pkt_data), 16'h25);
    chk("basic_par_vld", 16'(bus.pkt_valid), 16'd0);
    chk("basic_early_done", 16'(bus.done), 16'd0);
    tick();
    chk("basic_done", 16'(bus.done), 16'd1);
    chk("basic_count", bus.pkt_count, 16'd1);
    chk("basic_gap_data", 16'(bus.pkt_data), 16'h25);
    tick();
    chk("basic_done_pulse", 16'(bus.done), 16'd0);
    chk("basic_gap2_ready", 16'(bus.ready), 16'd0);
    tick();
    chk("basic_ready", 16'(bus.ready), 16'd1);

    // minimum packet, clean then corrupted
    min_pkt(1'b0, 8'h5C, 16'd2);
    min_pkt(1'b1, 8'h5D, 16'd3);

    // busy stall on payload byte 5
    req(2'd0, 6'd14, 8'hA5, 1'b0);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk($sformatf("stall_pay%0d", k), 16'(bus.pkt_data), 16'(pay[k]));
      if (k == 5) begin
        bus.busy = 1'b1;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("stall_hold", 16'(bus.pkt_data), 16'h98);
          chk("stall_vld", 16'(bus.pkt_valid), 16'd1);
        end
        bus.busy = 1'b0;
      end
    end
    tick(); chk("stall_par", 16'(bus.pkt_data), 16'h25);
    chk("stall_no_done", 16'(bus.done), 16'd0);
    tick(); chk("stall_done", 16'(bus.done), 16'd1);
    chk("stall_count", bus.pkt_count, 16'd4);
    gap_to_ready();

    // illegal requests
    req(2'd3, 6'd5, 8'h11, 1'b0);
    chk("rej_addr", 16'(bus.reject), 16'd1);
    chk("rej_addr_vld", 16'(bus.pkt_valid), 16'd0);
    chk("rej_addr_ready", 16'(bus.ready), 16'd1);
    tick();
    chk("rej_pulse", 16'(bus.reject), 16'd0);
    chk("rej_vld2", 16'(bus.pkt_valid), 16'd0);
    req(2'd1, 6'd0, 8'h11, 1'b0);
    chk("rej_len", 16'(bus.reject), 16'd1);
    chk("rej_len_vld", 16'(bus.pkt_valid), 16'd0);
    tick();
    chk("rej_len_pulse", 16'(bus.reject), 16'd0);
    chk("rej_count", bus.pkt_count, 16'd4);

    // start held high: addr1 len2 seed 01 -> 09, 01, B8, parity B0
    bus.start = 1'b1; bus.dest_addr = 2'd1; bus.payload_len = 6'd2; bus.seed = 8'h01; bus.corrupt = 1'b0;
    tick(); chk("held_hdr", 16'(bus.pkt_data), 16'h09);
    tick(); chk("held_p0", 16'(bus.pkt_data), 16'h01);
    tick(); chk("held_p1", 16'(bus.pkt_data), 16'hB8);
    tick(); chk("held_par", 16'(bus.pkt_data), 16'hB0);
    chk("held_par_vld", 16'(bus.pkt_valid), 16'd0);
    tick(); chk("held_done", 16'(bus.done), 16'd1);
    chk("held_gap1_vld", 16'(bus.pkt_valid), 16'd0);
    tick(); chk("held_gap2_vld", 16'(bus.pkt_valid), 16'd0);
    chk("held_gap2_ready", 16'(bus.ready), 16'd0);
    tick(); chk("held_ready", 16'(bus.ready), 16'd1);
    chk("held_idle_vld", 16'(bus.pkt_valid), 16'd0);
    chk("held_count1", bus.pkt_count, 16'd5);
    tick(); chk("held_hdr2", 16'(bus.pkt_data), 16'h09);
    chk("held_hdr2_vld", 16'(bus.pkt_valid), 16'd1);
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("held_count2", bus.pkt_count, 16'd6);
    gap_to_ready();

    // reset while payload byte 7 is on the bus
    req(2'd0, 6'd14, 8'hA5, 1'b0);
    for (int k = 0; k < 8; k++) tick();
    chk("mid_pay7", 16'(bus.pkt_data), 16'(pay[7]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_vld", 16'(bus.pkt_valid), 16'd0);
    chk("mid_ready", 16'(bus.ready), 16'd1);
    chk("mid_count", bus.pkt_count, 16'd0);
    chk("mid_data", 16'(bus.pkt_data), 16'h00);
    min_pkt(1'b0, 8'h5C, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
